spi_mem_master: RTL
===================

SPI_MEM_MASTER -- requirements
Module: spi_mem_master

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter addresswidth, default 7: width of the memory address carried in the command byte.
REQ-002 The block SHALL have parameter width, default 8: width of the data byte.
REQ-003 The block SHALL have parameter halfperiod, default 2: clk cycles per SCLK half-period; legal values are 1 or more.

Ports (name, direction, width, meaning):
REQ-004 The block SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset_n, input, 1: reset, asynchronous and active-low.
REQ-006 The block SHALL have port start, input, 1: transaction request, sampled only in IDLE.
REQ-007 The block SHALL have port rw, input, 1: transfer direction; 1=read, 0=write.
REQ-008 The block SHALL have port address, input, addresswidth: target memory address.
REQ-009 The block SHALL have port wdata, input, width: write data.
REQ-010 The block SHALL have port rdata, output, width: read result.
REQ-011 The block SHALL have port busy, output, 1: high whenever the state is not IDLE.
REQ-012 The block SHALL have port done, output, 1: one-cycle completion pulse.
REQ-013 The block SHALL have ports sclk, cs_n and mosi, each output, 1: the SPI bus signals (SPI mode 0).
REQ-014 The block SHALL have port miso, input, 1: SPI serial data from the memory.

Function
REQ-015 The FSM SHALL have states IDLE, SHIFT, HOLD and DONE.
REQ-016 In IDLE with start=1, the block SHALL latch rw, address and wdata at that clock edge and enter SHIFT.
  - Latched values are used for the whole transaction; input changes after acceptance have no effect.
REQ-017 start SHALL be ignored in every state other than IDLE.
REQ-018 The frame SHALL be 16 bits, MSB first:
  - First byte (command): {address, rw}.
  - Second byte on a write: wdata.
  - Second byte on a read: mosi driven 0.
REQ-019 In SHIFT, cs_n SHALL be 0 from the first cycle (acceptance edge + 1), and mosi SHALL present frame bit 15 in that same cycle.
REQ-020 sclk SHALL idle at 0 and then toggle as follows:
  - First rising edge occurs halfperiod cycles after cs_n falls.
  - Each level then lasts halfperiod cycles.
  - Exactly 16 rising and 16 falling edges occur per frame.
REQ-021 mosi SHALL change only in the cycle sclk falls (next bit) and SHALL remain stable while sclk is 1.
REQ-022 On a read, the block SHALL sample miso in the cycle sclk rises, for rising edges 9 to 16, and shift it into rdata MSB first.
REQ-023 rdata SHALL update only when a read completes; it SHALL hold its value through writes and idle time.
REQ-024 After the 16th falling edge, the FSM SHALL enter HOLD, with sclk=0 and cs_n=0, for halfperiod cycles; it then enters DONE.
REQ-025 DONE SHALL last exactly 1 cycle, with cs_n=1, done=1 and busy=1; the FSM then returns to IDLE.
REQ-026 Latency SHALL be fixed: done is high in cycle A+1+33*halfperiod, where A is the acceptance edge (cycle 67 for halfperiod=2).
REQ-027 If start is held high continuously, a new transaction SHALL be accepted in the first IDLE cycle after DONE, so cs_n is high for exactly 2 cycles between frames.
REQ-028 With halfperiod=1, sclk SHALL toggle every cycle and all rules above SHALL still hold.

Reset
REQ-029 While reset_n=0, the block SHALL immediately (asynchronously) force the following, regardless of clk:
  - state=IDLE
  - cs_n=1, sclk=0, mosi=0
  - busy=0, done=0
  - rdata=0
  - bit and phase counters cleared
REQ-030 A reset asserted mid-frame SHALL abort the frame with no done pulse; the first start after reset_n rises SHALL begin a complete new frame.

Verification
REQ-031 Write case, halfperiod=2, address=0x05, wdata=0xA5, rw=0:
  - mosi carries 0x0A then 0xA5 on the rising sclk edges.
  - done pulses at cycle A+67.
  - rdata is unchanged.
REQ-032 Read case, address=0x7F, rw=1, slave model drives 0x3C:
  - command byte is 0xFF and mosi=0 during the data byte.
  - rdata=0x3C in the done cycle and afterwards.
REQ-033 Start pulse at cycle A+10 during a frame -> no effect; the frame completes unchanged and exactly one done pulse occurs.
REQ-034 reset_n=0 at the 5th sclk rising edge:
  - cs_n=1 and sclk=0 in the same cycle, with no done pulse.
  - A new write to address 0x01 then completes normally.
REQ-035 start held high for two write frames -> cs_n high for exactly 2 cycles between frames, with two done pulses 68 cycles apart (halfperiod=2).
REQ-036 Read with halfperiod=1, slave drives 0x81 -> sclk toggles every cycle, rdata=0x81, and done at A+34.

Source files
------------

// File: rtl/spi_mem_master.sv
// SPI mode-0 master for a byte-addressed serial memory: 16-bit frame of {address, rw}
// followed by a data byte, with fixed latency and a one-cycle done pulse.
module spi_mem_master #(
  parameter int unsigned addresswidth = 7,
  parameter int unsigned width        = 8,
  parameter int unsigned halfperiod   = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic                    rw,
  input  logic [addresswidth-1:0] address,
  input  logic [width-1:0]        wdata,
  output logic [width-1:0]        rdata,
  output logic                    busy,
  output logic                    done,
  output logic                    sclk,
  output logic                    cs_n,
  output logic                    mosi,
  input  logic                    miso
);

  localparam int unsigned FrameW = addresswidth + 1 + width;
  localparam int unsigned HalfW  = $clog2(2 * FrameW);
  localparam int unsigned PhW    = (halfperiod > 1) ? $clog2(halfperiod) : 1;

  localparam logic [HalfW-1:0] LastHalf    = HalfW'(2 * FrameW - 1);
  // High half-periods of the data byte are the read sample points.
  localparam logic [HalfW-1:0] FirstRxHalf = HalfW'(2 * (addresswidth + 1));
  localparam logic [PhW-1:0]   LastPhase   = PhW'(halfperiod - 1);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StShift = 2'd1;
  localparam logic [1:0] StHold  = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [PhW-1:0]    phase_q, phase_d;
  logic [HalfW-1:0]  half_q, half_d;
  logic              sclk_q, sclk_d;
  logic              cs_n_q, cs_n_d;
  logic              mosi_q, mosi_d;
  logic              rw_q, rw_d;
  logic [FrameW-1:0] tx_q, tx_d;
  logic [width-1:0]  rx_q, rx_d;
  logic [width-1:0]  rdata_q, rdata_d;
  logic              phase_end;

  assign phase_end = (phase_q == LastPhase);

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    half_d  = half_q;
    sclk_d  = sclk_q;
    cs_n_d  = cs_n_q;
    mosi_d  = mosi_q;
    rw_d    = rw_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    rdata_d = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StShift;
          rw_d    = rw;
          tx_d    = {address, rw, wdata & {width{~rw}}};
          cs_n_d  = 1'b0;
          sclk_d  = 1'b0;
          mosi_d  = address[addresswidth-1];
          phase_d = '0;
          half_d  = '0;
        end
      end
      StShift: begin
        if (rw_q && half_q[0] && (half_q >= FirstRxHalf) && (phase_q == '0)) begin
          rx_d = {rx_q[width-2:0], miso};
        end
        if (phase_end) begin
          phase_d = '0;
          if (half_q == LastHalf) begin
            state_d = StHold;
            sclk_d  = 1'b0;
            mosi_d  = 1'b0;
          end else begin
            half_d = half_q + HalfW'(1);
            sclk_d = ~sclk_q;
            // Next bit goes out on the falling edge so it is stable across the high phase.
            if (sclk_q) begin
              tx_d   = {tx_q[FrameW-2:0], 1'b0};
              mosi_d = tx_q[FrameW-2];
            end
          end
        end else begin
          phase_d = phase_q + PhW'(1);
        end
      end
      StHold: begin
        if (phase_end) begin
          state_d = StDone;
          cs_n_d  = 1'b1;
          phase_d = '0;
          if (rw_q) begin
            rdata_d = rx_q;
          end
        end else begin
          phase_d = phase_q + PhW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      phase_q <= '0;
      half_q  <= '0;
      sclk_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      mosi_q  <= 1'b0;
      rw_q    <= 1'b0;
      tx_q    <= '0;
      rx_q    <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      half_q  <= half_d;
      sclk_q  <= sclk_d;
      cs_n_q  <= cs_n_d;
      mosi_q  <= mosi_d;
      rw_q    <= rw_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;
  assign busy  = (state_q != StIdle);
  assign done  = (state_q == StDone);
  assign sclk  = sclk_q;
  assign cs_n  = cs_n_q;
  assign mosi  = mosi_q;

endmodule
